// File: rtl/usr_pkg.sv
// ============================================================================
// Module   : usr_pkg
// Brief    : Mode/state encodings and mode-class helper for univ_shift_reg_n.
//            Rotate modes count as shift modes only when USR_ROTATE_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package usr_pkg;

    typedef enum logic [2:0] {
        HOLD = 3'd0,
        SHR  = 3'd1,
        SHL  = 3'd2,
        LOAD = 3'd3,
        ASR  = 3'd4,
        ROR  = 3'd5,
        ROL  = 3'd6,
        RSVD = 3'd7
    } usr_mode_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } usr_state_e;

    // Modes that move bits and therefore consume burst steps.
    function automatic logic is_shift(input usr_mode_e m);
        logic r;
        r = 1'b0;
        case (m)
            SHR, SHL, ASR: r = 1'b1;
`ifdef USR_ROTATE_EN
            ROR, ROL:      r = 1'b1;
`endif
            default:       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/usr_step_unit.sv
// ============================================================================
// Module   : usr_step_unit
// Brief    : Combinational single-step next-q / next-so for one mode.
//            Rotate decode present only when USR_ROTATE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usr_step_unit
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic             sr_i,
    input  logic             sl_i,
    input  logic             so_i,
    output logic [WIDTH-1:0] q_o,
    output logic             so_o
);

    usr_mode_e w_mode;
    assign w_mode = usr_mode_e'(mode_i);

    always_comb begin
        q_o  = q_i;
        so_o = so_i;
        case (w_mode)
            SHR: begin
                q_o  = {sr_i, q_i[WIDTH-1:1]};
                so_o = q_i[0];
            end
            SHL: begin
                q_o  = {q_i[WIDTH-2:0], sl_i};
                so_o = q_i[WIDTH-1];
            end
            LOAD: begin
                q_o  = data_in_i;
            end
            ASR: begin
                q_o  = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
                so_o = q_i[0];
            end
`ifdef USR_ROTATE_EN
            ROR: begin
                q_o  = {q_i[0], q_i[WIDTH-1:1]};
                so_o = q_i[0];
            end
            ROL: begin
                q_o  = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
                so_o = q_i[WIDTH-1];
            end
`endif
            default: begin
                q_o  = q_i;
                so_o = so_i;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/univ_shift_reg_n.sv
// ============================================================================
// Module   : univ_shift_reg_n
// Brief    : WIDTH-generic universal shift register with start/busy/done
//            burst engine. Optional rotate modes via macro USR_ROTATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_reg_n
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             sr,
    input  logic             sl,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] c_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_ZERO = '0;

    usr_state_e       state_q, state_d;
    usr_mode_e        mode_q,  mode_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic             so_q,    so_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    usr_mode_e        w_live_mode;
    logic [2:0]       w_step_mode;
    logic [WIDTH-1:0] w_step_q;
    logic             w_step_so;

    assign w_live_mode = usr_mode_e'(mode);
    // In RUN the latched mode drives the datapath; live mode is ignored.
    assign w_step_mode = (state_q == RUN) ? mode_q : mode;

    usr_step_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode_i    (w_step_mode),
        .q_i       (q_q),
        .data_in_i (data_in),
        .sr_i      (sr),
        .sl_i      (sl),
        .so_i      (so_q),
        .q_o       (w_step_q),
        .so_o      (w_step_so)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= HOLD;
            rem_q   <= c_ZERO;
            q_q     <= '0;
            so_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            so_q    <= so_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        q_d     = q_q;
        so_d    = so_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = w_live_mode;
                    if (count == c_ZERO) begin
                        done_d = 1'b1;
                    end else if (w_live_mode == LOAD) begin
                        q_d    = w_step_q;
                        done_d = 1'b1;
                    end else if (is_shift(w_live_mode)) begin
                        q_d   = w_step_q;
                        so_d  = w_step_so;
                        rem_d = count - c_ONE;
                        if (count == c_ONE) begin
                            done_d = 1'b1;
                        end else begin
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (en) begin
                    q_d  = w_step_q;
                    so_d = w_step_so;
                end
            end
            RUN: begin
                q_d   = w_step_q;
                so_d  = w_step_so;
                rem_d = rem_q - c_ONE;
                if (rem_q == c_ONE) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign q    = q_q;
    assign so   = so_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg_n.sv
// ============================================================================
// Module   : tb_univ_shift_reg_n
// Brief    : Directed scoreboard bench for univ_shift_reg_n (WIDTH=8, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_univ_shift_reg_n;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst, en, sr, sl, start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] data_in;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q;
    logic             so, busy, done;

    typedef struct {
        int               tag;
        logic [WIDTH-1:0] q;
        logic             so;
        logic             busy;
        logic             done;
        logic             chk_so;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   tag_n  = 0;

    always #5 clk = ~clk;

    univ_shift_reg_n #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .data_in (data_in),
        .sr      (sr),
        .sl      (sl),
        .start   (start),
        .count   (count),
        .q       (q),
        .so      (so),
        .busy    (busy),
        .done    (done)
    );

    // Monitor: after each active edge, pop one expected post-edge state.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (q !== e.q || busy !== e.busy || done !== e.done ||
                (e.chk_so && so !== e.so)) begin
                n_fail++;
                $display("FAIL vec%0d: got q=%h so=%b busy=%b done=%b, want q=%h so=%b busy=%b done=%b",
                         e.tag, q, so, busy, done, e.q, e.so, e.busy, e.done);
            end
        end
    end

    // Drive one cycle of inputs and queue the state expected after that edge.
    task automatic cyc(input logic r, input logic e, input logic [2:0] m,
                       input logic [7:0] d, input logic s_r, input logic s_l,
                       input logic st, input logic [3:0] c,
                       input logic [7:0] eq, input logic eso,
                       input logic ebusy, input logic edone, input logic cso);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; mode = m; data_in = d; sr = s_r; sl = s_l;
        start = st; count = c;
        x.tag = tag_n; x.q = eq; x.so = eso; x.busy = ebusy;
        x.done = edone; x.chk_so = cso;
        tag_n++;
        exp_q.push_back(x);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 3'd0; data_in = '0; sr = 1'b0;
        sl = 1'b0; start = 1'b0; count = '0;

        //   rst en mode data   sr sl st cnt   q     so busy done chkso
        cyc(1, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0, 0, 1);
        cyc(0, 1, 3'd3, 8'hA5, 0, 0, 0, 4'd0, 8'hA5, 0, 0, 0, 1);
        cyc(0, 1, 3'd1, 8'h00, 0, 0, 0, 4'd0, 8'h52, 1, 0, 0, 1);
        // Reserved mode single step holds.
        cyc(0, 1, 3'd7, 8'h00, 1, 1, 0, 4'd0, 8'h52, 1, 0, 0, 1);

        // Burst SHL x3 from 0x81, sl=1.
        cyc(0, 1, 3'd3, 8'h81, 0, 0, 0, 4'd0, 8'h81, 1, 0, 0, 1);
        cyc(0, 0, 3'd2, 8'h00, 0, 1, 1, 4'd3, 8'h03, 1, 1, 0, 1);
        cyc(0, 0, 3'd0, 8'h00, 0, 1, 0, 4'd0, 8'h07, 0, 1, 0, 1);
        cyc(0, 0, 3'd0, 8'h00, 0, 1, 0, 4'd0, 8'h0F, 0, 0, 1, 1);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h0F, 0, 0, 0, 1);

        // Burst ASR x2 from 0x90.
        cyc(0, 1, 3'd3, 8'h90, 0, 0, 0, 4'd0, 8'h90, 0, 0, 0, 1);
        cyc(0, 0, 3'd4, 8'h00, 0, 0, 1, 4'd2, 8'hC8, 0, 1, 0, 1);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'hE4, 0, 0, 1, 1);
        // count=0 and HOLD bursts: no change, done next cycle, never busy.
        cyc(0, 0, 3'd1, 8'h00, 1, 1, 1, 4'd0, 8'hE4, 0, 0, 1, 1);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 1, 4'd4, 8'hE4, 0, 0, 1, 1);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'hE4, 0, 0, 0, 1);

        // ROR x1 from 0x01.
        cyc(0, 1, 3'd3, 8'h01, 0, 0, 0, 4'd0, 8'h01, 0, 0, 0, 1);
`ifdef USR_ROTATE_EN
        cyc(0, 0, 3'd5, 8'h00, 0, 0, 1, 4'd1, 8'h80, 1, 0, 1, 1);
`else
        cyc(0, 0, 3'd5, 8'h00, 0, 0, 1, 4'd1, 8'h01, 0, 0, 1, 1);
`endif

        // SHR x5 from 0xF0 with interfering en/mode/start/count.
        cyc(0, 1, 3'd3, 8'hF0, 0, 0, 0, 4'd0, 8'hF0, 0, 0, 0, 0);
        cyc(0, 0, 3'd1, 8'h00, 1, 0, 1, 4'd5, 8'hF8, 0, 1, 0, 1);
        cyc(0, 1, 3'd2, 8'h33, 0, 0, 1, 4'd3, 8'h7C, 0, 1, 0, 1);
        cyc(0, 1, 3'd3, 8'h33, 1, 0, 1, 4'd3, 8'hBE, 0, 1, 0, 1);
        cyc(0, 1, 3'd2, 8'h33, 0, 1, 1, 4'd1, 8'h5F, 0, 1, 0, 1);
        cyc(0, 1, 3'd4, 8'h33, 1, 0, 0, 4'd0, 8'hAF, 1, 0, 1, 1);
        // Start in the done cycle: SHL x1, sl=0.
        cyc(0, 0, 3'd2, 8'h00, 0, 0, 1, 4'd1, 8'h5E, 1, 0, 1, 1);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h5E, 1, 0, 0, 1);

        // Reset during step 2 of a SHL x6 burst.
        cyc(0, 1, 3'd3, 8'h01, 0, 0, 0, 4'd0, 8'h01, 1, 0, 0, 1);
        cyc(0, 0, 3'd2, 8'h00, 0, 1, 1, 4'd6, 8'h03, 0, 1, 0, 1);
        cyc(1, 0, 3'd0, 8'h00, 0, 1, 0, 4'd0, 8'h00, 0, 0, 0, 1);
        cyc(0, 0, 3'd0, 8'h00, 0, 1, 0, 4'd0, 8'h00, 0, 0, 0, 1);
        cyc(0, 0, 3'd2, 8'h00, 0, 1, 1, 4'd2, 8'h01, 0, 1, 0, 1);
        cyc(0, 0, 3'd0, 8'h00, 0, 1, 0, 4'd0, 8'h03, 0, 0, 1, 1);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h03, 0, 0, 0, 1);

        @(negedge clk);
        start = 1'b0; en = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
